div_unit: RTL and testbench

- Multi-cycle 32-bit integer divider for the 54-instruction CPU; executes DIV (signed) and DIVU (unsigned).
- Performs the operation the single-cycle ALU cannot: one restoring-division step per clock, WIDTH iterations.
- Results go to the HI/LO path: quotient to LO, remainder to HI.
- The controller stalls on busy and captures results on done.

---
 rtl/div_unit.sv | 103 ++++++++++
 tb/tb_div_unit.sv | 97 +++++++++
 2 files changed

// File: rtl/div_unit.sv
// div_unit: multi-cycle restoring divider (DIV/DIVU), one quotient bit per clock
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sign,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d, dvs_q, dvs_d, raw_q, raw_d, q_q, q_d, r_q, r_d;
  logic             negq_q, negq_d, negr_q, negr_d, zero_q, zero_d, dz_q, dz_d;
  logic             accept, last;
  logic [WIDTH:0]   r_sh, r_nx;
  logic [WIDTH+1:0] trial;
  logic [WIDTH-1:0] q_nx, a_mag, b_mag;
  always_comb begin
    accept  = start && state_q != RUN;
    last    = state_q == RUN && cnt_q == CW'(WIDTH - 1);
    a_mag   = (sign && dividend[WIDTH-1]) ? -dividend : dividend;
    b_mag   = (sign && divisor[WIDTH-1]) ? -divisor : divisor;
    r_sh    = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    trial   = {1'b0, r_sh} - {2'b0, dvs_q};
    r_nx    = trial[WIDTH+1] ? r_sh : trial[WIDTH:0];
    q_nx    = {quo_q[WIDTH-2:0], ~trial[WIDTH+1]};
    state_d = accept ? RUN : last ? FIN : state_q == RUN ? RUN : IDLE;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    raw_d   = raw_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    zero_d  = zero_q;
    q_d     = q_q;
    r_d     = r_q;
    dz_d    = dz_q;
    if (accept) begin
      negq_d = sign && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
      negr_d = sign && dividend[WIDTH-1];
      zero_d = divisor == '0;
      raw_d  = dividend;
      dvs_d  = b_mag;
      quo_d  = a_mag;
      rem_d  = '0;
      cnt_d  = '0;
    end else if (state_q == RUN) begin
      rem_d = r_nx;
      quo_d = q_nx;
      cnt_d = cnt_q + 1'b1;
    end
    if (last) begin
      q_d  = zero_q ? '1 : negq_q ? -q_nx : q_nx;
      r_d  = zero_q ? raw_q : negr_q ? -r_nx[WIDTH-1:0] : r_nx[WIDTH-1:0];
      dz_d = zero_q;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      raw_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      zero_q  <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      raw_q   <= raw_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      zero_q  <= zero_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
    end
  end
  assign q        = q_q;
  assign r        = r_q;
  assign div_zero = dz_q;
  assign busy     = state_q == RUN;
  assign done     = state_q == FIN;
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed checks of div_unit results, latency, handshake and reset
module tb_div_unit;
  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, sign = 1'b0;
  logic [31:0] dividend = '0, divisor = '0, q, r;
  logic        busy, done, div_zero;
  int          total = 0, bad = 0;
  div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .sign(sign),
    .dividend(dividend), .divisor(divisor),
    .q(q), .r(r), .busy(busy), .done(done), .div_zero(div_zero)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic start_op(input logic s, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    sign = s; dividend = a; divisor = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_done(input string tag, input int nb, input logic [31:0] eq,
                           input logic [31:0] er, input logic ez);
    int n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk({tag, "_busy_cycles"}, n, nb);
    chk({tag, "_done"}, {31'b0, done}, 1);
    chk({tag, "_q"}, q, eq);
    chk({tag, "_r"}, r, er);
    chk({tag, "_dz"}, {31'b0, div_zero}, {31'b0, ez});
  endtask
  task automatic op(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] eq, input logic [31:0] er, input logic ez);
    start_op(s, a, b);
    wait_done(tag, 32, eq, er, ez);
    @(negedge clk);
    chk({tag, "_done_low"}, {31'b0, done}, 0);
  endtask
  initial begin
    int seen;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_q", q, 0);
    chk("rst_r", r, 0);
    chk("rst_flags", {28'b0, busy, done, div_zero}, 0);
    op("u100_7", 1'b0, 32'd100, 32'd7, 32'h0000000E, 32'h2, 1'b0);
    op("uffff_2", 1'b0, 32'hFFFFFFFF, 32'h2, 32'h7FFFFFFF, 32'h1, 1'b0);
    op("s_m7_2", 1'b1, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
    op("s_7_m2", 1'b1, 32'h7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h1, 1'b0);
    op("s_m7_m2", 1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h3, 32'hFFFFFFFF, 1'b0);
    op("s_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0, 1'b0);
    op("u_80000000_1", 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0);
    op("dz_u", 1'b0, 32'h12345678, 32'h0, 32'hFFFFFFFF, 32'h12345678, 1'b1);
    op("dz_s", 1'b1, 32'h12345678, 32'h0, 32'hFFFFFFFF, 32'h12345678, 1'b1);
    op("dz_clear", 1'b0, 32'h12345678, 32'h10, 32'h01234567, 32'h8, 1'b0);
    op("dvd_zero", 1'b1, 32'h0, 32'h5, 32'h0, 32'h0, 1'b0);
    start_op(1'b0, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    dividend = 32'd50; divisor = 32'd5; sign = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; dividend = 32'd999; divisor = 32'd3;
    wait_done("ign", 27, 32'd14, 32'd2, 1'b0);
    dividend = 32'd50; divisor = 32'd5; sign = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy", {31'b0, busy}, 1);
    chk("b2b_done", {31'b0, done}, 0);
    chk("b2b_q_hold", q, 32'd14);
    chk("b2b_r_hold", r, 32'd2);
    wait_done("b2b", 32, 32'd10, 32'd0, 1'b0);
    op("dz_pre_rst", 1'b0, 32'hCAFE0001, 32'h0, 32'hFFFFFFFF, 32'hCAFE0001, 1'b1);
    start_op(1'b0, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_q", q, 0);
    chk("mid_rst_r", r, 0);
    chk("mid_rst_flags", {28'b0, busy, done, div_zero}, 0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    chk("mid_rst_no_done", seen, 0);
    op("post_rst", 1'b1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
